// File: rtl/zoom_scan_if.sv
// ROM fetch and pixel-stream bundle between the zoom scan controller and its surroundings.
// master = controller side, slave = ROM/consumer side.
interface zoom_scan_if #(
    parameter int XW = 8,
    parameter int YW = 7
);
    logic [XW-1:0] x_img;
    logic [YW-1:0] y_img;
    logic          flow_enabled;
    logic [7:0]    mem_pixel;
    logic          mem_valid;
    logic [7:0]    out_pixel;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;

    modport master (
        output x_img, y_img, flow_enabled,
        input  mem_pixel, mem_valid,
        output out_pixel, out_valid, out_sof, out_eol,
        input  out_ready
    );

    modport slave (
        input  x_img, y_img, flow_enabled,
        output mem_pixel, mem_valid,
        input  out_pixel, out_valid, out_sof, out_eol,
        output out_ready
    );
endinterface

// File: rtl/zoom_scan_ctrl.sv
// Frame scan sequencer: walks a zoomed output frame, fetches each source pixel from a
// 1-cycle-latency ROM and streams it out through a 2-entry credit-controlled buffer.
module zoom_scan_ctrl #(
    parameter int IMG_WIDTH   = 160,
    parameter int IMG_HEIGHT  = 120,
    parameter int ZOOM_FACTOR = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic zoom_en,
    output logic busy,
    output logic done,
    zoom_scan_if.master bus
);
    localparam int XW = (IMG_WIDTH   > 1) ? $clog2(IMG_WIDTH)   : 1;
    localparam int YW = (IMG_HEIGHT  > 1) ? $clog2(IMG_HEIGHT)  : 1;
    localparam int ZW = (ZOOM_FACTOR > 1) ? $clog2(ZOOM_FACTOR) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);
    localparam logic [ZW-1:0] Z_MAX = ZW'(ZOOM_FACTOR - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic last;
    } tag_t;

    typedef struct packed {
        logic [7:0] pixel;
        tag_t       tag;
    } entry_t;

    state_t        state_q, state_d;
    logic          zoom_q, zoom_d;
    logic [ZW-1:0] zx_q, zx_d, zy_q, zy_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic          inflight_q, inflight_d;
    tag_t          tag_q, tag_d;
    entry_t        fifo_q [2];
    entry_t        fifo_d [2];
    logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    logic [ZW-1:0] zmax;
    logic          zx_end, sx_end, zy_end, sy_end;
    logic          fetch, last_fetch, push, pop, out_valid;
    tag_t          fetch_tag;
    entry_t        head;

    assign zmax   = zoom_q ? Z_MAX : '0;
    assign zx_end = (zx_q == zmax);
    assign sx_end = (sx_q == X_MAX);
    assign zy_end = (zy_q == zmax);
    assign sy_end = (sy_q == Y_MAX);

    assign fetch_tag.sof  = (zx_q == '0) && (sx_q == '0) && (zy_q == '0) && (sy_q == '0);
    assign fetch_tag.eol  = sx_end && zx_end;
    assign fetch_tag.last = sx_end && zx_end && sy_end && zy_end;

    assign head      = fifo_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.mem_valid;
    assign pop       = out_valid && bus.out_ready;

    // Credit: buffered + in-flight pixels, minus the one leaving this cycle, must leave room.
    assign fetch      = (state_q == RUN) &&
                        ((3'(count_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);
    assign last_fetch = fetch && fetch_tag.last;

    assign bus.flow_enabled = fetch;
    assign bus.x_img        = sx_q;
    assign bus.y_img        = sy_q;
    assign bus.out_valid    = out_valid;
    assign bus.out_pixel    = head.pixel;
    assign bus.out_sof      = out_valid && head.tag.sof;
    assign bus.out_eol      = out_valid && head.tag.eol;

    // NOTE: every _d gets its hold value first, so no path through the block leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_fetch) state_d = DRAIN;
            DRAIN:   if (pop && head.tag.last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan order, innermost first: zx, sx, zy, sy.
    always_comb begin
        zoom_d = zoom_q;
        zx_d   = zx_q;
        sx_d   = sx_q;
        zy_d   = zy_q;
        sy_d   = sy_q;
        if ((state_q == IDLE) && start) begin
            zoom_d = zoom_en;
            zx_d   = '0;
            sx_d   = '0;
            zy_d   = '0;
            sy_d   = '0;
        end else if (fetch) begin
            if (!zx_end) begin
                zx_d = zx_q + 1'b1;
            end else begin
                zx_d = '0;
                if (!sx_end) begin
                    sx_d = sx_q + 1'b1;
                end else begin
                    sx_d = '0;
                    if (!zy_end) begin
                        zy_d = zy_q + 1'b1;
                    end else begin
                        zy_d = '0;
                        sy_d = sy_end ? '0 : sy_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        inflight_d = fetch;
        tag_d      = fetch ? fetch_tag : tag_q;
        fifo_d     = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{pixel: bus.mem_pixel, tag: tag_q};
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    // NOTE: sequential state is written with <= so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            zoom_q     <= 1'b0;
            zx_q       <= '0;
            sx_q       <= '0;
            zy_q       <= '0;
            sy_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            zoom_q     <= zoom_d;
            zx_q       <= zx_d;
            sx_q       <= sx_d;
            zy_q       <= zy_d;
            sy_q       <= sy_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: buffer payload is not reset; count_q and the pointers alone define which
    // entries are valid, and the stream markers are gated by out_valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_zoom_scan_ctrl.sv
// Directed bench for zoom_scan_ctrl on a 4x2 image with zoom factor 2, with a
// 1-cycle-latency ROM model returning pixel value {row, column}.
module tb_zoom_scan_ctrl;
    localparam int W = 4;
    localparam int H = 2;
    localparam int Z = 2;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] pixel;
    } px_t;

    logic clk = 1'b0;
    logic reset, start, zoom_en;
    logic busy, done;

    int  errors = 0;
    int  checks = 0;
    px_t exp_q[$];
    bit  ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    zoom_scan_if #(.XW(2), .YW(1)) bus ();

    zoom_scan_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ZOOM_FACTOR(Z)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .zoom_en(zoom_en),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_valid <= 1'b0;
            bus.mem_pixel <= 8'h00;
        end else begin
            bus.mem_valid <= bus.flow_enabled;
            bus.mem_pixel <= {4'(bus.y_img), 4'(bus.x_img)};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: z selects zoom, rnd randomises out_ready, abort_at resets after that
    // many accepted pixels, poke pulses start mid-frame and during DONE.
    task automatic run_frame(input bit z, input bit rnd, input int abort_at, input bit poke);
        int  zf, n, idx, cyc, occ, first_valid, done_cyc, done_cnt;
        bit  infl, pop, stalled, finished, aborted;
        px_t prev, got, e;
        zf = z ? Z : 1;
        exp_q.delete();
        for (int sy = 0; sy < H; sy++)
            for (int zy = 0; zy < zf; zy++)
                for (int sx = 0; sx < W; sx++)
                    for (int zx = 0; zx < zf; zx++) begin
                        e.sof   = (exp_q.size() == 0);
                        e.eol   = (sx == W - 1) && (zx == zf - 1);
                        e.pixel = {4'(sy), 4'(sx)};
                        exp_q.push_back(e);
                    end
        n = exp_q.size();
        idx = 0; occ = 0; infl = 0; stalled = 0; prev = '0;
        first_valid = 0; done_cyc = 0; done_cnt = 0; finished = 0; aborted = 0;

        check("idle_before_start", 32'(busy), 0);
        start   = 1'b1;
        zoom_en = z;
        @(posedge clk); @(negedge clk);
        start   = 1'b0;
        zoom_en = ~z;
        cyc = 1;
        while (!finished && cyc <= 400) begin
            if (!rnd) bus.out_ready = 1'b1;
            else if (cyc >= 3 && cyc < 7) bus.out_ready = ready_pat[cyc - 3];
            else bus.out_ready = 1'($urandom_range(0, 1));
            if (poke) start = (cyc == 10);
            #1;
            if (done_cnt != 0) begin
                check("busy_after_done", 32'(busy), 0);
                check("done_one_cycle", 32'(done), 0);
                finished = 1;
            end else begin
                if (cyc == 1) begin
                    check("first_fetch", 32'(bus.flow_enabled), 1);
                    check("first_xy", 32'({bus.y_img, bus.x_img}), 0);
                    check("busy_running", 32'(busy), 1);
                end
                if (bus.out_valid && first_valid == 0) first_valid = cyc;
                got.sof   = bus.out_sof;
                got.eol   = bus.out_eol;
                got.pixel = bus.out_pixel;
                if (stalled) begin
                    check("stall_valid", 32'(bus.out_valid), 1);
                    check("stall_data", 32'(got), 32'(prev));
                end
                pop = bus.out_valid && bus.out_ready;
                if (bus.flow_enabled)
                    check("credit", 32'((occ + int'(infl) - int'(pop)) < 2), 1);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (poke) start = 1'b1;
                end
                if (pop) begin
                    if (idx < n) check($sformatf("pixel_%0d", idx + 1), 32'(got), 32'(exp_q[idx]));
                    else check("extra_pixel", idx, n - 1);
                    idx++;
                    if (abort_at != 0 && idx == abort_at) begin
                        reset = 1'b1;
                        #1;
                        check("reset_outputs", 32'({busy, done, bus.flow_enabled, bus.out_valid,
                              bus.out_sof, bus.out_eol, bus.x_img, bus.y_img}), 0);
                        @(posedge clk); @(negedge clk);
                        reset = 1'b0;
                        #1;
                        check("reset_idle", 32'(busy), 0);
                        finished = 1;
                        aborted  = 1;
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                prev    = got;
                occ     = occ + int'(bus.mem_valid) - int'(pop);
                infl    = bus.flow_enabled;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            check("abort_no_done", done_cnt, 0);
        end else begin
            check("frame_done_count", done_cnt, 1);
            check("frame_pixel_count", idx, n);
            check("first_valid_cycle", first_valid, 3);
            if (!rnd) check("done_cycle", done_cyc, n + 3);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        zoom_en = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'({busy, done, bus.flow_enabled, bus.out_valid,
              bus.out_sof, bus.out_eol, bus.x_img, bus.y_img}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_frame(1'b1, 1'b0, 0, 1'b0);   // zoomed frame, full rate
        run_frame(1'b0, 1'b0, 0, 1'b0);   // 1:1 frame
        run_frame(1'b1, 1'b1, 0, 1'b0);   // back-pressure
        run_frame(1'b1, 1'b0, 0, 1'b1);   // spurious starts ignored
        run_frame(1'b0, 1'b0, 0, 1'b0);   // next start accepted from IDLE
        run_frame(1'b1, 1'b0, 10, 1'b0);  // reset mid-frame
        run_frame(1'b1, 1'b0, 0, 1'b0);   // full frame after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
